// File: rtl/serial_sub_4.sv
// Bit-serial subtractor D = A - B - Bin, one bit per clock LSB first, with Start/Busy/Done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output V.
module serial_sub_4 #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB_OVF_EN
  output logic             V,
`endif
  output logic             Bout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d, done_q, done_d;
  logic             bit_a, bit_b, bit_d, bit_br;

`ifdef SERIAL_SUB_OVF_EN
  logic amsb_q, amsb_d, bmsb_q, bmsb_d, v_q, v_d;
`endif

  assign bit_a  = a_q[0];
  assign bit_b  = b_q[0];
  assign bit_d  = bit_a ^ bit_b ^ br_q;
  assign bit_br = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    d_d     = d_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    v_d     = v_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          res_d   = '0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          amsb_d  = A[WIDTH-1];
          bmsb_d  = B[WIDTH-1];
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Result fills from the MSB side so after WIDTH shifts bit 0 sits at res_q[0].
        res_d = {bit_d, res_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bit_br;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_DONE;
      end
      S_DONE: begin
        d_d     = res_q;
        bout_d  = br_q;
        done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
        v_d     = (amsb_q != bmsb_q) & (res_q[WIDTH-1] != amsb_q);
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      v_q     <= v_d;
`endif
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign V    = v_q;
`endif

endmodule
